// File: rtl/rca_seq_add_ctrl.sv
// Sequential W-bit adder built by time-sharing one N-bit RCA slice, LSB slice first.
// Optional subtract mode when SEQ_ADD_SUB_EN is defined (adds a `sub` input).

module RCA #(
    parameter int N = 4
) (
    output logic         Cout,
    output logic [N-1:0] Sum,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin
);
    logic [N:0] c;

    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int unsigned i = 0; i < N; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[N];
    end
endmodule

module rca_seq_add_ctrl #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Sum,
    output logic         Cout
);
    localparam int CW = ($clog2(W / N) > 1) ? $clog2(W / N) : 1;
    localparam logic [CW-1:0] LAST = CW'(W / N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((N < 1) || (W % N != 0)) begin : g_bad_params
            $error("rca_seq_add_ctrl: W must be a positive multiple of N");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d, cout_q, cout_d, ov_q, ov_d;

    logic [N-1:0]  rca_sum;
    logic          rca_cout;
    logic [W-1:0]  sum_shift;

    RCA #(.N(N)) u_rca (
        .Cout (rca_cout),
        .Sum  (rca_sum),
        .A    (a_q[N-1:0]),
        .B    (b_q[N-1:0]),
        .Cin  (carry_q)
    );

    // New slice result enters at the top while the accumulated result moves down.
    generate
        if (W == N) begin : g_one_slice
            assign sum_shift = rca_sum;
        end else begin : g_multi_slice
            assign sum_shift = {rca_sum, sum_q[W-1:N]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SEQ_ADD_SUB_EN
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
`else
                    b_d     = B;
                    carry_d = Cin;
`endif
                end
            end
            S_RUN: begin
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                sum_d   = sum_shift;
                carry_d = rca_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = rca_cout;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign out_valid = ov_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
endmodule
